// File: rtl/dma_pkg.sv
// Shared definitions for the DMA device-side arbiter: FSM state encoding and device-count limits.
// State names are ASCII-encoded when SIM is defined, so waveforms show them as readable text.
package dma_pkg;

  localparam int NUM_DEV_MIN = 2;
  localparam int NUM_DEV_MAX = 8;

`ifdef SIM
  typedef enum logic [55:0] {
    IDLE    = 56'("IDLE"),
    BUSY    = 56'("BUSY"),
    RELEASE = 56'("RELEASE")
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;
`endif

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: one-hot grant and index from a request vector.
// Round-robin starts at start_i; with DMA_ARB_FIXED_PRIO_EN the lowest index always wins.
module rr_picker #(
  parameter int NUM_DEV   = 4,
  parameter int DEV_IDX_W = 2
) (
  input  logic [NUM_DEV-1:0]   req_i,
`ifndef DMA_ARB_FIXED_PRIO_EN
  input  logic [DEV_IDX_W-1:0] start_i,
`endif
  output logic [NUM_DEV-1:0]   gnt_o,
  output logic [DEV_IDX_W-1:0] idx_o,
  output logic                 valid_o
);

  int                   cand;
  logic [DEV_IDX_W-1:0] candIdx;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
`ifdef DMA_ARB_FIXED_PRIO_EN
      cand = k;
`else
      // Walk forward from the start index, wrapping at NUM_DEV.
      cand = int'(start_i) + k;
      if (cand >= NUM_DEV) cand = cand - NUM_DEV;
`endif
      candIdx = DEV_IDX_W'(cand);
      if (!valid_o && req_i[candIdx]) begin
        valid_o        = 1'b1;
        idx_o          = candIdx;
        gnt_o[candIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_dev_arbiter.sv
// Shares the single dma_controller device port among NUM_DEV requesters; a grant is held until end_flag.
// Round-robin by default; defining DMA_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module dma_dev_arbiter
  import dma_pkg::*;
#(
  parameter int ADD_LEN   = 16,
  parameter int DATA_LEN  = 16,
  parameter int NUM_DEV   = 4,
  parameter int DEV_IDX_W = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_DEV-1:0]             dev_rqst,
  input  logic [NUM_DEV-1:0]             dev_rd_wr,
  input  logic [NUM_DEV*ADD_LEN-1:0]     dev_num_words,
  input  logic [NUM_DEV*(ADD_LEN+1)-1:0] dev_start_addr,
  input  logic [NUM_DEV-1:0]             dev_ack_in,
  input  logic [NUM_DEV*DATA_LEN-1:0]    dev_data_in,
  output logic [NUM_DEV-1:0]             dev_dma_ack,
  output logic [NUM_DEV-1:0]             dev_end_flag,
  output logic [DATA_LEN-1:0]            dev_data_out,
  output logic [NUM_DEV-1:0]             dev_grant,
  output logic                           arb_busy,
  output logic                           dma_rqst,
  output logic                           dma_rd_wr,
  output logic [ADD_LEN-1:0]             dma_num_words,
  output logic [ADD_LEN:0]               dma_start_addr,
  output logic                           dma_dev_ack,
  output logic [DATA_LEN-1:0]            dma_dev_in,
  input  logic                           dma_ack,
  input  logic                           dma_end_flag,
  input  logic [DATA_LEN-1:0]            dma_dev_out
);

  arb_state_e           state_q, state_d;
  logic [DEV_IDX_W-1:0] cur_q, cur_d;
  logic [NUM_DEV-1:0]   grant_q, grant_d;
  logic [NUM_DEV-1:0]   pickGnt;
  logic [DEV_IDX_W-1:0] pickIdx;
  logic                 pickValid;
  logic                 busy;

`ifndef DMA_ARB_FIXED_PRIO_EN
  logic [DEV_IDX_W-1:0] last_q, last_d;
  logic [DEV_IDX_W-1:0] startIdx;

  // Search begins one past the last winner; reset value makes device 0 win first.
  always_comb begin
    startIdx = (last_q == DEV_IDX_W'(NUM_DEV-1)) ? '0 : last_q + 1'b1;
    last_d   = (state_q == IDLE && pickValid) ? pickIdx : last_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= DEV_IDX_W'(NUM_DEV-1);
    else        last_q <= last_d;
  end

  rr_picker #(.NUM_DEV(NUM_DEV), .DEV_IDX_W(DEV_IDX_W)) u_picker (
    .req_i   (dev_rqst),
    .start_i (startIdx),
    .gnt_o   (pickGnt),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );
`else
  rr_picker #(.NUM_DEV(NUM_DEV), .DEV_IDX_W(DEV_IDX_W)) u_picker (
    .req_i   (dev_rqst),
    .gnt_o   (pickGnt),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      grant_q <= grant_d;
    end
  end

  // RELEASE holds dma_rqst low so the controller cannot re-trigger on a stale request.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d = BUSY;
          cur_d   = pickIdx;
          grant_d = pickGnt;
        end
      end
      BUSY: begin
        if (dma_end_flag) begin
          state_d = RELEASE;
          grant_d = '0;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign busy      = (state_q == BUSY);
  assign arb_busy  = busy;
  assign dev_grant = grant_q;

  // Descriptor and handshakes pass through combinationally from the granted device.
  always_comb begin
    dma_rqst       = 1'b0;
    dma_rd_wr      = 1'b0;
    dma_num_words  = '0;
    dma_start_addr = '0;
    dma_dev_ack    = 1'b0;
    dma_dev_in     = '0;
    dev_dma_ack    = '0;
    dev_end_flag   = '0;
    dev_data_out   = dma_dev_out;
    if (busy) begin
      dma_rqst             = 1'b1;
      dma_rd_wr            = dev_rd_wr[cur_q];
      dma_num_words        = dev_num_words[int'(cur_q)*ADD_LEN +: ADD_LEN];
      dma_start_addr       = dev_start_addr[int'(cur_q)*(ADD_LEN+1) +: ADD_LEN+1];
      dma_dev_ack          = dev_ack_in[cur_q];
      dma_dev_in           = dev_data_in[int'(cur_q)*DATA_LEN +: DATA_LEN];
      dev_dma_ack[cur_q]   = dma_ack;
      dev_end_flag[cur_q]  = dma_end_flag;
    end
  end

endmodule

// File: tb/tb_dma_dev_arbiter.sv
// Self-checking bench for dma_dev_arbiter (default round-robin build): directed sequences,
// a per-cycle vector table, and randomized traffic against a transaction-level reference model.
module tb_dma_dev_arbiter;

  localparam int ADD_LEN   = 16;
  localparam int DATA_LEN  = 16;
  localparam int NUM_DEV   = 4;
  localparam int DEV_IDX_W = 2;

  logic                           clk = 1'b0;
  logic                           reset;
  logic [NUM_DEV-1:0]             dev_rqst;
  logic [NUM_DEV-1:0]             dev_rd_wr;
  logic [NUM_DEV*ADD_LEN-1:0]     dev_num_words;
  logic [NUM_DEV*(ADD_LEN+1)-1:0] dev_start_addr;
  logic [NUM_DEV-1:0]             dev_ack_in;
  logic [NUM_DEV*DATA_LEN-1:0]    dev_data_in;
  logic [NUM_DEV-1:0]             dev_dma_ack;
  logic [NUM_DEV-1:0]             dev_end_flag;
  logic [DATA_LEN-1:0]            dev_data_out;
  logic [NUM_DEV-1:0]             dev_grant;
  logic                           arb_busy;
  logic                           dma_rqst;
  logic                           dma_rd_wr;
  logic [ADD_LEN-1:0]             dma_num_words;
  logic [ADD_LEN:0]               dma_start_addr;
  logic                           dma_dev_ack;
  logic [DATA_LEN-1:0]            dma_dev_in;
  logic                           dma_ack;
  logic                           dma_end_flag;
  logic [DATA_LEN-1:0]            dma_dev_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_dev_arbiter #(
    .ADD_LEN(ADD_LEN), .DATA_LEN(DATA_LEN), .NUM_DEV(NUM_DEV), .DEV_IDX_W(DEV_IDX_W)
  ) dut (
    .clk(clk), .reset(reset),
    .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr), .dev_num_words(dev_num_words),
    .dev_start_addr(dev_start_addr), .dev_ack_in(dev_ack_in), .dev_data_in(dev_data_in),
    .dev_dma_ack(dev_dma_ack), .dev_end_flag(dev_end_flag), .dev_data_out(dev_data_out),
    .dev_grant(dev_grant), .arb_busy(arb_busy), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_num_words(dma_num_words), .dma_start_addr(dma_start_addr), .dma_dev_ack(dma_dev_ack),
    .dma_dev_in(dma_dev_in), .dma_ack(dma_ack), .dma_end_flag(dma_end_flag),
    .dma_dev_out(dma_dev_out)
  );

  typedef struct {
    logic [NUM_DEV-1:0] rq;
    logic               ef;
    logic [NUM_DEV-1:0] expGrant;
    logic               expRqst;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setDesc(input int d, input logic rw, input logic [ADD_LEN-1:0] nw,
                         input logic [ADD_LEN:0] sa);
    dev_rd_wr[d]                                = rw;
    dev_num_words[d*ADD_LEN +: ADD_LEN]         = nw;
    dev_start_addr[d*(ADD_LEN+1) +: ADD_LEN+1]  = sa;
  endtask

  task automatic applyReset();
    reset          = 1'b0;
    dev_rqst       = '0;
    dev_rd_wr      = '0;
    dev_num_words  = '0;
    dev_start_addr = '0;
    dev_ack_in     = '0;
    dev_data_in    = '0;
    dma_ack        = 1'b0;
    dma_end_flag   = 1'b0;
    dma_dev_out    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input logic [NUM_DEV-1:0] rq, input logic ef);
    dev_rqst     = rq;
    dma_end_flag = ef;
    tick();
  endtask

  // Ends the current transfer with requests already dropped; leaves the arbiter in IDLE.
  task automatic finishTransfer();
    dma_end_flag = 1'b1;
    tick();
    dma_end_flag = 1'b0;
    tick();
  endtask

  // Reference model state: owning device (-1 = none), release cycle pending, last winner.
  int  mOwner;
  bit  mCool;
  int  mLast;

  task automatic modelCheck(input int cyc);
    logic [NUM_DEV-1:0]  eGrant, eAck, eEnd;
    logic                eRw, eDevAck;
    logic [ADD_LEN-1:0]  eNw;
    logic [ADD_LEN:0]    eSa;
    logic [DATA_LEN-1:0] eIn;
    eGrant = '0; eAck = '0; eEnd = '0;
    eRw = 1'b0; eDevAck = 1'b0; eNw = '0; eSa = '0; eIn = '0;
    if (mOwner >= 0) begin
      eGrant[mOwner] = 1'b1;
      eAck[mOwner]   = dma_ack;
      eEnd[mOwner]   = dma_end_flag;
      eRw            = dev_rd_wr[mOwner];
      eDevAck        = dev_ack_in[mOwner];
      eNw            = dev_num_words[mOwner*ADD_LEN +: ADD_LEN];
      eSa            = dev_start_addr[mOwner*(ADD_LEN+1) +: ADD_LEN+1];
      eIn            = dev_data_in[mOwner*DATA_LEN +: DATA_LEN];
    end
    checkOutput($sformatf("rnd%0d grant", cyc), dev_grant, eGrant);
    checkOutput($sformatf("rnd%0d busy", cyc), arb_busy, mOwner >= 0);
    checkOutput($sformatf("rnd%0d rqst", cyc), dma_rqst, mOwner >= 0);
    checkOutput($sformatf("rnd%0d rd_wr", cyc), dma_rd_wr, eRw);
    checkOutput($sformatf("rnd%0d num_words", cyc), dma_num_words, eNw);
    checkOutput($sformatf("rnd%0d start_addr", cyc), dma_start_addr, eSa);
    checkOutput($sformatf("rnd%0d dev_ack", cyc), dma_dev_ack, eDevAck);
    checkOutput($sformatf("rnd%0d dev_in", cyc), dma_dev_in, eIn);
    checkOutput($sformatf("rnd%0d dev_dma_ack", cyc), dev_dma_ack, eAck);
    checkOutput($sformatf("rnd%0d dev_end_flag", cyc), dev_end_flag, eEnd);
    checkOutput($sformatf("rnd%0d data_out", cyc), dev_data_out, dma_dev_out);
  endtask

  task automatic modelAdvance();
    if (mOwner >= 0) begin
      if (dma_end_flag) begin
        mOwner = -1;
        mCool  = 1'b1;
      end
    end else if (mCool) begin
      mCool = 1'b0;
    end else if (dev_rqst != '0) begin
      for (int k = 1; k <= NUM_DEV; k++) begin
        int d;
        d = (mLast + k) % NUM_DEV;
        if (dev_rqst[d]) begin
          mOwner = d;
          mLast  = d;
          break;
        end
      end
    end
  endtask

  initial begin
    vecs[0]  = '{4'b1011, 1'b0, 4'b0001, 1'b1};
    vecs[1]  = '{4'b1011, 1'b1, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1011, 1'b0, 4'b0000, 1'b0};
    vecs[3]  = '{4'b1011, 1'b0, 4'b0010, 1'b1};
    vecs[4]  = '{4'b1011, 1'b1, 4'b0000, 1'b0};
    vecs[5]  = '{4'b1011, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{4'b1011, 1'b0, 4'b1000, 1'b1};
    vecs[7]  = '{4'b1011, 1'b1, 4'b0000, 1'b0};
    vecs[8]  = '{4'b1011, 1'b0, 4'b0000, 1'b0};
    vecs[9]  = '{4'b1011, 1'b0, 4'b0001, 1'b1};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0};

    applyReset();
    checkOutput("reset grant", dev_grant, 4'b0000);
    checkOutput("reset rqst", dma_rqst, 1'b0);
    checkOutput("reset busy", arb_busy, 1'b0);

    // Single read on device 2: descriptor forwarding, routed acks, end pulse and release gap.
    setDesc(2, 1'b1, 16'd4, 17'h0200);
    dev_rqst = 4'b0100;
    tick();
    checkOutput("rd grant", dev_grant, 4'b0100);
    checkOutput("rd rqst", dma_rqst, 1'b1);
    checkOutput("rd start_addr", dma_start_addr, 17'h0200);
    checkOutput("rd num_words", dma_num_words, 16'd4);
    checkOutput("rd rd_wr", dma_rd_wr, 1'b1);
    for (int i = 0; i < 4; i++) begin
      dma_ack      = 1'b1;
      dma_dev_out  = 16'hC000 + 16'(i);
      dma_end_flag = (i == 3);
      #1;
      checkOutput($sformatf("rd ack%0d", i), dev_dma_ack, 4'b0100);
      checkOutput($sformatf("rd data%0d", i), dev_data_out, 16'hC000 + 16'(i));
      checkOutput($sformatf("rd end%0d", i), dev_end_flag, (i == 3) ? 4'b0100 : 4'b0000);
      tick();
    end
    dma_ack      = 1'b0;
    dma_end_flag = 1'b0;
    checkOutput("rd release rqst", dma_rqst, 1'b0);
    checkOutput("rd release end", dev_end_flag, 4'b0000);
    tick();
    checkOutput("rd idle rqst", dma_rqst, 1'b0);
    tick();
    checkOutput("rd regrant", dev_grant, 4'b0100);
    dev_rqst = '0;
    finishTransfer();

    // Device 1 write: data from device 1 only, handshake routed to bit 1 only.
    dev_data_in = 64'hDEAD_BEEF_CAFE_F00D;
    setDesc(1, 1'b0, 16'd3, 17'h0300);
    dev_rqst = 4'b0010;
    tick();
    checkOutput("wr grant", dev_grant, 4'b0010);
    dev_rqst = '0;
    for (int i = 0; i < 3; i++) begin
      logic [DATA_LEN-1:0] w;
      w = (i == 0) ? 16'hA5A5 : (i == 1) ? 16'h5A5A : 16'h1234;
      dev_data_in[DATA_LEN +: DATA_LEN] = w;
      dev_ack_in = 4'b0010;
      dma_ack    = 1'b1;
      #1;
      checkOutput($sformatf("wr dev_in%0d", i), dma_dev_in, w);
      checkOutput($sformatf("wr dev_ack%0d", i), dma_dev_ack, 1'b1);
      checkOutput($sformatf("wr dma_ack%0d", i), dev_dma_ack, 4'b0010);
      tick();
    end
    dev_ack_in = '0;
    dma_ack    = 1'b0;
    finishTransfer();

    // Zero-length transfer on device 0 completes immediately, then device 1 follows.
    setDesc(0, 1'b1, 16'd0, 17'h0100);
    dev_rqst = 4'b0011;
    tick();
    checkOutput("zero grant", dev_grant, 4'b0001);
    checkOutput("zero num_words", dma_num_words, 16'd0);
    dma_end_flag = 1'b1;
    #1;
    checkOutput("zero end", dev_end_flag, 4'b0001);
    tick();
    dma_end_flag = 1'b0;
    checkOutput("zero release", dev_grant, 4'b0000);
    tick();
    checkOutput("zero idle rqst", dma_rqst, 1'b0);
    tick();
    checkOutput("zero next grant", dev_grant, 4'b0010);
    dev_rqst = '0;
    finishTransfer();

    // Granted device withdraws its request: grant persists until end_flag.
    dev_rqst = 4'b0100;
    tick();
    dev_rqst = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("drop grant%0d", i), dev_grant, 4'b0100);
      checkOutput($sformatf("drop rqst%0d", i), dma_rqst, 1'b1);
    end
    finishTransfer();
    checkOutput("drop released", dev_grant, 4'b0000);

    // Asynchronous reset during a transfer clears outputs and the round-robin pointer.
    dev_rqst = 4'b0010;
    tick();
    checkOutput("rst pre grant", dev_grant, 4'b0010);
    dev_rqst = 4'b1111;
    dma_ack  = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst async grant", dev_grant, 4'b0000);
    checkOutput("rst async rqst", dma_rqst, 1'b0);
    checkOutput("rst async busy", arb_busy, 1'b0);
    checkOutput("rst async ack", dev_dma_ack, 4'b0000);
    tick();
    reset   = 1'b1;
    dma_ack = 1'b0;
    tick();
    checkOutput("rst first grant", dev_grant, 4'b0001);

    // Held requests from devices 0, 1, 3 rotate through the table.
    applyReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rq, vecs[i].ef);
      checkOutput($sformatf("vec%0d grant", i), dev_grant, vecs[i].expGrant);
      checkOutput($sformatf("vec%0d rqst", i), dma_rqst, vecs[i].expRqst);
      checkOutput($sformatf("vec%0d busy", i), arb_busy, vecs[i].expRqst);
    end

    // Randomized traffic compared against the reference model.
    applyReset();
    mOwner = -1;
    mCool  = 1'b0;
    mLast  = NUM_DEV - 1;
    for (int c = 0; c < 400; c++) begin
      dev_rqst       = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      dev_rd_wr      = 4'($urandom_range(0, 15));
      dev_num_words  = {$urandom, $urandom};
      dev_start_addr = {4'($urandom), $urandom, $urandom};
      dev_ack_in     = 4'($urandom_range(0, 15));
      dev_data_in    = {$urandom, $urandom};
      dma_ack        = 1'($urandom_range(0, 1));
      dma_end_flag   = ($urandom_range(0, 3) == 0);
      dma_dev_out    = 16'($urandom);
      #1;
      modelCheck(c);
      @(posedge clk);
      modelAdvance();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_dev_arbiter.md
# dma_dev_arbiter

Shares the single `dma_controller` device-side port among up to NUM_DEV peripheral requesters. Selects one pending device and forwards its transfer descriptor (`rd_wr`, `num_words`, `start_addr`) and data handshake to the DMA controller. Holds the grant until the controller signals `end_flag`, then releases and re-arbitrates. Sits between the peripheral bus devices and `dma_controller`; the OpenMSP430 side is untouched.

## Interface
- ADD_LEN, 16, physical address / word-count width (device addresses are ADD_LEN+1, logical)
- DATA_LEN, 16, data word width
- NUM_DEV, 4, number of requesting devices (2..8)
- DEV_IDX_W, 2, index width, ceil(log2(NUM_DEV))

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dev_rqst  in  NUM_DEV  per-device transfer request, level
- dev_rd_wr  in  NUM_DEV  per-device direction (1 = read memory to device)
- dev_num_words  in  NUM_DEV*ADD_LEN  packed word counts, device i at [i*ADD_LEN +: ADD_LEN]
- dev_start_addr  in  NUM_DEV*(ADD_LEN+1)  packed logical start addresses
- dev_ack_in  in  NUM_DEV  per-device data-ready/accept handshake
- dev_data_in  in  NUM_DEV*DATA_LEN  packed write data from devices
- dev_dma_ack  out  NUM_DEV  dma_ack routed to granted device only
- dev_end_flag  out  NUM_DEV  end_flag routed to granted device only
- dev_data_out  out  DATA_LEN  read data, broadcast; valid only with own dev_dma_ack
- dev_grant  out  NUM_DEV  one-hot grant, registered
- arb_busy  out  1  transfer in progress
- dma_rqst  out  1  to controller `rqst`
- dma_rd_wr  out  1  to controller `rd_wr`
- dma_num_words  out  ADD_LEN  to controller `num_words`
- dma_start_addr  out  ADD_LEN+1  to controller `start_addr`
- dma_dev_ack  out  1  to controller `dev_ack`
- dma_dev_in  out  DATA_LEN  to controller `dev_in`
- dma_ack  in  1  from controller `dma_ack`
- dma_end_flag  in  1  from controller `end_flag`
- dma_dev_out  in  DATA_LEN  from controller `dev_out`

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- IDLE: if any dev_rqst → latch winner index `cur`, latch pointer, go BUSY; else stay.
- BUSY: dma_rqst=1; descriptor and dev_ack/dev_in muxed from `cur`; dma_ack→dev_dma_ack[cur], dma_end_flag→dev_end_flag[cur] (combinational). On dma_end_flag → RELEASE.
- RELEASE: dma_rqst=0 for one cycle (controller sits in IDLE and must not re-trigger); → IDLE.
- Outside BUSY: all dma_* outputs and dev_dma_ack/dev_end_flag/dev_grant driven 0; dev_data_out = dma_dev_out always.
- Round-robin: search starts at last_grant+1 modulo NUM_DEV; last_grant resets to NUM_DEV-1 so device 0 wins first.
- Granted device dropping dev_rqst in BUSY: ignored; transfer runs to dma_end_flag (controller has no abort).
- num_words = 0: controller returns end_flag immediately; arbiter treats it as a normal completion.
- Reset mid-transfer: state IDLE, all outputs 0, last_grant = NUM_DEV-1; controller is reset separately.

## Timing
- Request sampled at edge k in IDLE → dev_grant, arb_busy, dma_rqst high after edge k; descriptor stable from same cycle until RELEASE.
- dma_end_flag high at edge m → RELEASE after m, IDLE after m+1; earliest next dma_rqst after m+2.
- Minimum gap between transfers: 2 idle cycles of dma_rqst.
- Handshake paths (dev_ack, dma_ack, data) are combinational, zero added latency.

## Configuration
- DMA_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; last_grant register removed.
- Undefined (default): round-robin as above.

## Structure
- Shared package/header `dma_pkg`: state encodings (ASCII under SIM, as in the controller), NUM_DEV limit constants.
- One sub-module: `rr_picker` (combinational request vector + pointer → one-hot winner and index); fixed-priority mode bypasses the pointer.

## Test plan
- Single device 2 reads num_words=4, start_addr=0x0200 → dma_start_addr=0x0200, dev_grant=0100, dev_end_flag[2] pulses once, dma_rqst low exactly 1 cycle in RELEASE.
- Devices 0,1,3 request together, held → grant order 0,1,3,0 (round-robin); with DMA_ARB_FIXED_PRIO_EN → 0,0,0.
- Device 1 write of 3 words, dev_data_in[1]=0xA5A5,0x5A5A,0x1234 → dma_dev_in matches; dev_dma_ack asserted only on bit 1.
- num_words=0 on device 0 → immediate end_flag, arbiter returns to IDLE, device 1 granted next.
- Granted device drops rqst mid-transfer → grant held until dma_end_flag.
- reset low during BUSY → all outputs 0 asynchronously; after release device 0 granted first.
